alu_issue_ctrl: RTL

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_issue_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one op at a time to an external ALU, times its latency.
// Define ALU_ISSUE_FORWARD_EN to forward the last captured result to operands.
module alu_issue_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MUL_LATENCY    = 5,
  parameter int ALU_LATENCY    = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [1:0]                in_op,
  input  logic [DATA_WIDTH-1:0]     in_first,
  input  logic [DATA_WIDTH-1:0]     in_second,
  input  logic [REG_ADDR_WIDTH-1:0] in_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] in_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] in_rd,
  output logic [DATA_WIDTH-1:0]     alu_first,
  output logic [DATA_WIDTH-1:0]     alu_second,
  output logic [1:0]                alu_op,
  input  logic [DATA_WIDTH-1:0]     alu_result,
  input  logic                      alu_zero,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_result,
  output logic                      out_zero,
  output logic [REG_ADDR_WIDTH-1:0] out_rd,
  output logic                      busy
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    WAIT_OUT
  } state_t;

  state_t                    state;
  logic [3:0]                cnt;
  logic [REG_ADDR_WIDTH-1:0] rd_q;
  logic                      accept;
  logic                      capture;
  logic [3:0]                lat_m1;
  logic [DATA_WIDTH-1:0]     first_n;
  logic [DATA_WIDTH-1:0]     second_n;

  assign in_ready = (state == IDLE) ||
                    ((state == WAIT_OUT) && out_ready);
  assign accept   = in_valid && in_ready;
  assign capture  = (state == EXEC) && (cnt == 4'd0);
  assign busy     = (state != IDLE);
  assign lat_m1   = (in_op == 2'b10) ? 4'(MUL_LATENCY - 1)
                                     : 4'(ALU_LATENCY - 1);

`ifdef ALU_ISSUE_FORWARD_EN
  logic fwd_valid;
  logic fwd1;
  logic fwd2;

  assign fwd1 = fwd_valid && (in_rs1 == out_rd) && (in_rs1 != '0);
  assign fwd2 = fwd_valid && (in_rs2 == out_rd) && (in_rs2 != '0);
  assign first_n  = fwd1 ? out_result : in_first;
  assign second_n = fwd2 ? out_result : in_second;

  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_valid <= 1'b0;
    end else if (capture) begin
      fwd_valid <= 1'b1;
    end
  end
`else
  logic unused_rs;

  assign unused_rs = ^{in_rs1, in_rs2};
  assign first_n   = in_first;
  assign second_n  = in_second;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      rd_q       <= '0;
      alu_first  <= '0;
      alu_second <= '0;
      alu_op     <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_zero   <= 1'b0;
      out_rd     <= '0;
    end else begin
      if (accept) begin
        alu_first  <= first_n;
        alu_second <= second_n;
        alu_op     <= in_op;
        rd_q       <= in_rd;
        cnt        <= lat_m1;
      end
      unique case (state)
        IDLE: begin
          if (accept) state <= EXEC;
        end
        EXEC: begin
          if (capture) begin
            out_result <= alu_result;
            out_zero   <= alu_zero;
            out_rd     <= rd_q;
            out_valid  <= 1'b1;
            state      <= WAIT_OUT;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        WAIT_OUT: begin
          // A fresh accept here chains straight into EXEC.
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= accept ? EXEC : IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
